// File: rtl/spacer_fifo.sv
// spacer_fifo: circular sample FIFO that re-emits buffered samples with out_nd
// pulses spaced at least SPACING cycles apart. Metadata rides with each sample,
// overflow sets a sticky error flag, and occupancy is exported as fill.
module spacer_fifo #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned MWIDTH    = 1,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned LOG_DEPTH = 4,
    parameter int unsigned SPACING   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_nd,
    input  logic [MWIDTH-1:0]    in_m,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_nd,
    output logic [MWIDTH-1:0]    out_m,
    output logic                 error,
    output logic [LOG_DEPTH:0]   fill
);

    // Gap counter only needs to hold SPACING-1; keep at least one bit so
    // SPACING == 1 still elaborates (the counter then stays at 0).
    localparam int unsigned GapW = (SPACING > 1) ? $clog2(SPACING) : 1;
    localparam logic [LOG_DEPTH:0] FullCnt   = (LOG_DEPTH + 1)'(DEPTH);
    localparam logic [GapW-1:0]    GapReload = GapW'(SPACING - 1);

    logic [WIDTH+MWIDTH-1:0] mem_q [DEPTH];

    logic [LOG_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [LOG_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [LOG_DEPTH:0]   fill_q, fill_d;
    logic [GapW-1:0]      gap_q, gap_d;
    logic [WIDTH-1:0]     out_data_q, out_data_d;
    logic [MWIDTH-1:0]    out_m_q, out_m_d;
    logic                 out_nd_q, out_nd_d;
    logic                 error_q, error_d;

    logic pop;
    logic push;
    logic overflow;

    // Decide pop/push for this edge and compute all next-state values.
    always_comb begin
        pop      = (fill_q != '0) && (gap_q == '0);
        // A full FIFO still accepts a write when the same edge frees a slot.
        push     = in_nd && ((fill_q != FullCnt) || pop);
        overflow = in_nd && (fill_q == FullCnt) && !pop;

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        gap_d      = gap_q;
        out_data_d = out_data_q;
        out_m_d    = out_m_q;
        out_nd_d   = 1'b0;
        error_d    = error_q | overflow;

        if (push) begin
            wr_ptr_d = wr_ptr_q + LOG_DEPTH'(1);
        end

        if (pop) begin
            {out_data_d, out_m_d} = mem_q[rd_ptr_q];
            out_nd_d              = 1'b1;
            rd_ptr_d              = rd_ptr_q + LOG_DEPTH'(1);
            gap_d                 = GapReload;
        end else if (gap_q != '0) begin
            gap_d = gap_q - GapW'(1);
        end

        fill_d = fill_q + {LOG_DEPTH'(0), push} - {LOG_DEPTH'(0), pop};
    end

    // Sample storage; contents are don't-care after reset since pointers clear.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_data, in_m};
        end
    end

    // Control state and registered outputs, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_q     <= '0;
            gap_q      <= '0;
            out_data_q <= '0;
            out_m_q    <= '0;
            out_nd_q   <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fill_q     <= fill_d;
            gap_q      <= gap_d;
            out_data_q <= out_data_d;
            out_m_q    <= out_m_d;
            out_nd_q   <= out_nd_d;
            error_q    <= error_d;
        end
    end

    assign out_data = out_data_q;
    assign out_m    = out_m_q;
    assign out_nd   = out_nd_q;
    assign error    = error_q;
    assign fill     = fill_q;

endmodule

// File: tb/tb_spacer_fifo.sv
// Directed bench for spacer_fifo: five instances with different DEPTH/SPACING
// share clock, reset and input data; each has its own in_nd.
module tb_spacer_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in_data;
    logic [0:0]  in_m;
    logic        nd_a, nd_b, nd_c, nd_d, nd_e;

    logic [31:0] od_a, od_b, od_c, od_d, od_e;
    logic [0:0]  om_a, om_b, om_c, om_d, om_e;
    logic        on_a, on_b, on_c, on_d, on_e;
    logic        er_a, er_b, er_c, er_d, er_e;
    logic [4:0]  fl_a, fl_b;
    logic [2:0]  fl_c, fl_d, fl_e;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // a: defaults (DEPTH 16, SPACING 2)
    spacer_fifo #(.WIDTH(32), .MWIDTH(1), .DEPTH(16), .LOG_DEPTH(4), .SPACING(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_nd(nd_a), .in_m(in_m),
        .out_data(od_a), .out_nd(on_a), .out_m(om_a), .error(er_a), .fill(fl_a));
    // b: burst pacing
    spacer_fifo #(.WIDTH(32), .MWIDTH(1), .DEPTH(16), .LOG_DEPTH(4), .SPACING(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_nd(nd_b), .in_m(in_m),
        .out_data(od_b), .out_nd(on_b), .out_m(om_b), .error(er_b), .fill(fl_b));
    // c: overflow and reset
    spacer_fifo #(.WIDTH(32), .MWIDTH(1), .DEPTH(4), .LOG_DEPTH(2), .SPACING(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_nd(nd_c), .in_m(in_m),
        .out_data(od_c), .out_nd(on_c), .out_m(om_c), .error(er_c), .fill(fl_c));
    // d: back-to-back output
    spacer_fifo #(.WIDTH(32), .MWIDTH(1), .DEPTH(4), .LOG_DEPTH(2), .SPACING(1)) dut_d (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_nd(nd_d), .in_m(in_m),
        .out_data(od_d), .out_nd(on_d), .out_m(om_d), .error(er_d), .fill(fl_d));
    // e: pointer wrap-around
    spacer_fifo #(.WIDTH(32), .MWIDTH(1), .DEPTH(4), .LOG_DEPTH(2), .SPACING(2)) dut_e (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_nd(nd_e), .in_m(in_m),
        .out_data(od_e), .out_nd(on_e), .out_m(om_e), .error(er_e), .fill(fl_e));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          exp_idx;
        int          peak;
        logic [31:0] exp_c [7];
        exp_c = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd9};

        rst_n   = 1'b0;
        in_data = 32'h0;
        in_m    = 1'b0;
        {nd_a, nd_b, nd_c, nd_d, nd_e} = '0;

        // in_nd during reset is ignored
        nd_a = 1'b1;
        tick();
        tick();
        nd_a = 1'b0;
        #2 rst_n = 1'b1;
        chk("reset_fill_a", 32'(fl_a), 32'd0);
        chk("reset_outnd_a", 32'(on_a), 32'd0);
        chk("reset_outdata_a", od_a, 32'd0);
        chk("reset_error_a", 32'(er_a), 32'd0);
        tick();
        chk("reset_nd_ignored_fill_a", 32'(fl_a), 32'd0);
        chk("reset_nd_ignored_outnd_a", 32'(on_a), 32'd0);

        // Single sample, SPACING 2
        in_data = 32'h0000_0005;
        in_m    = 1'b1;
        nd_a    = 1'b1;
        tick();
        nd_a    = 1'b0;
        in_m    = 1'b0;
        chk("single_nd_e0", 32'(on_a), 32'd0);
        chk("single_fill_e0", 32'(fl_a), 32'd1);
        tick();
        chk("single_nd_e1", 32'(on_a), 32'd1);
        chk("single_data_e1", od_a, 32'd5);
        chk("single_m_e1", 32'(om_a), 32'd1);
        chk("single_fill_e1", 32'(fl_a), 32'd0);
        tick();
        chk("single_nd_e2", 32'(on_a), 32'd0);
        chk("single_fill_e2", 32'(fl_a), 32'd0);
        chk("single_error", 32'(er_a), 32'd0);

        // Burst pacing, SPACING 3: pops at edges 1,4,...,22
        exp_idx = 0;
        peak    = 0;
        for (int i = 0; i < 26; i++) begin
            nd_b    = (i < 8);
            in_data = 32'(i + 1);
            tick();
            if (32'(fl_b) > 32'(peak)) peak = int'(fl_b);
            if (i >= 1 && ((i - 1) % 3) == 0 && i <= 22) begin
                chk("burst_nd", 32'(on_b), 32'd1);
                chk("burst_data", od_b, 32'(exp_idx + 1));
                exp_idx++;
            end else begin
                chk("burst_idle", 32'(on_b), 32'd0);
            end
        end
        nd_b = 1'b0;
        chk("burst_count", 32'(exp_idx), 32'd8);
        chk("burst_peak_fill", 32'(peak), 32'd5);
        chk("burst_fill_end", 32'(fl_b), 32'd0);
        chk("burst_error", 32'(er_b), 32'd0);

        // Overflow, DEPTH 4 SPACING 4: 6,7,8 dropped; full+pop accepts 5 and 9
        exp_idx = 0;
        for (int i = 0; i < 30; i++) begin
            nd_c    = (i < 10);
            in_data = 32'(i);
            tick();
            chk("ovf_error", 32'(er_c), (i >= 6) ? 32'd1 : 32'd0);
            if (i == 5 || i == 9) chk("ovf_full_pop_fill", 32'(fl_c), 32'd4);
            if (i >= 1 && ((i - 1) % 4) == 0 && i <= 25) begin
                chk("ovf_nd", 32'(on_c), 32'd1);
                chk("ovf_data", od_c, exp_c[exp_idx]);
                exp_idx++;
            end else begin
                chk("ovf_idle", 32'(on_c), 32'd0);
            end
        end
        nd_c = 1'b0;
        chk("ovf_count", 32'(exp_idx), 32'd7);
        chk("ovf_fill_end", 32'(fl_c), 32'd0);

        // Refill c to 4 with error still set, then reset between edges
        for (int i = 0; i < 6; i++) begin
            nd_c    = 1'b1;
            in_data = 32'h10 + 32'(i);
            tick();
        end
        nd_c = 1'b0;
        chk("prereset_fill", 32'(fl_c), 32'd4);
        chk("prereset_error", 32'(er_c), 32'd1);
        chk("prereset_nd", 32'(on_c), 32'd1);
        chk("prereset_data", od_c, 32'h11);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_fill", 32'(fl_c), 32'd0);
        chk("async_reset_error", 32'(er_c), 32'd0);
        chk("async_reset_nd", 32'(on_c), 32'd0);
        chk("async_reset_data", od_c, 32'd0);
        #1 rst_n = 1'b1;
        tick();
        in_data = 32'hA;
        nd_c    = 1'b1;
        tick();
        nd_c = 1'b0;
        chk("post_reset_nd_e0", 32'(on_c), 32'd0);
        chk("post_reset_fill_e0", 32'(fl_c), 32'd1);
        tick();
        chk("post_reset_nd_e1", 32'(on_c), 32'd1);
        chk("post_reset_data", od_c, 32'hA);
        tick();
        chk("post_reset_fill_end", 32'(fl_c), 32'd0);

        // SPACING 1: continuous stream, one pop per cycle
        for (int i = 0; i < 14; i++) begin
            nd_d    = (i < 12);
            in_data = 32'h100 + 32'(i);
            tick();
            chk("s1_fill", 32'(fl_d), (i <= 11) ? 32'd1 : 32'd0);
            if (i >= 1 && i <= 12) begin
                chk("s1_nd", 32'(on_d), 32'd1);
                chk("s1_data", od_d, 32'h100 + 32'(i - 1));
            end else begin
                chk("s1_idle", 32'(on_d), 32'd0);
            end
        end
        nd_d = 1'b0;
        chk("s1_error", 32'(er_d), 32'd0);

        // Wrap-around, DEPTH 4 SPACING 2: 20 samples every other cycle
        for (int i = 0; i < 42; i++) begin
            nd_e    = ((i % 2) == 0) && (i < 40);
            in_data = 32'h200 + 32'(i / 2);
            tick();
            chk("wrap_fill", 32'(fl_e), (((i % 2) == 0) && (i < 40)) ? 32'd1 : 32'd0);
            if ((i % 2) == 1 && i <= 39) begin
                chk("wrap_nd", 32'(on_e), 32'd1);
                chk("wrap_data", od_e, 32'h200 + 32'((i - 1) / 2));
            end else begin
                chk("wrap_idle", 32'(on_e), 32'd0);
            end
        end
        nd_e = 1'b0;
        chk("wrap_error", 32'(er_e), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
